serial_word_collector: RTL

- Downstream stage of the 4-bit universal shift register; consumes its serial `out` bit stream one bit per strobe.
- Reassembles the bits into WIDTH-bit words, LSB-first (right-shift mode) or MSB-first (left-shift mode).
- Presents each completed word on a valid/ready output port.
- The serial source cannot stall, so a word that completes while the output slot is still occupied is dropped and flagged.

---
 rtl/serial_collect_pkg.sv | 22 ++
 rtl/word_hold_reg.sv | 78 +++++++
 rtl/serial_word_collector.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/serial_collect_pkg.sv
// Shared definitions for the serial word collector: default word width,
// collector state encoding, counter-width and even-parity helpers.
package serial_collect_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PARITY  = 1'b1
    } collect_state_e;

    // Bits needed to hold a count from 0 up to and including width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    // Even parity over up to 32 bits; unused upper bits are passed as zero.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/word_hold_reg.sv
// One-entry output slot for the serial word collector.
// Accepts a completed word when empty or when its current word drains in the
// same cycle; otherwise the incoming word is dropped and overrun is set.
// overrun is sticky until ovr_clr, and a simultaneous drop beats the clear.
module word_hold_reg
    import serial_collect_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_req,
    input  logic [WIDTH-1:0] load_word,
    input  logic             load_perr,
    input  logic             word_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             parity_err,
    output logic             overrun
);

    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ovr_q, ovr_d;
    logic             drain_s;
    logic             slot_free_s;

    // Slot arbitration: load beats drain, drop sets overrun.
    always_comb begin
        drain_s     = valid_q && word_ready;
        slot_free_s = !valid_q || drain_s;
        word_d      = word_q;
        valid_d     = valid_q;
        perr_d      = perr_q;
        ovr_d       = ovr_q;

        if (load_req && slot_free_s) begin
            word_d  = load_word;
            perr_d  = load_perr;
            valid_d = 1'b1;
        end else if (drain_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (load_req && !slot_free_s) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // Slot and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;

endmodule

// File: rtl/serial_word_collector.sv
// Serial-to-parallel word collector fed by the universal shift register.
// Bits are shifted into an accumulator LSB-first or MSB-first (direction
// latched on bit 0 of each word). A completed word is staged for one clock
// and then offered to the word_hold_reg output slot, so word_valid rises one
// clock after the last accepting edge.
// Optional build macro PARITY_CHECK_EN: each frame carries a trailing
// even-parity bit; bit_count holds at WIDTH while that bit is awaited.
module serial_word_collector
    import serial_collect_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    input  logic                     msb_first,
    input  logic                     flush,
    input  logic                     word_ready,
    input  logic                     ovr_clr,
    output logic [WIDTH-1:0]         word_out,
    output logic                     word_valid,
    output logic [cnt_w(WIDTH)-1:0]  bit_count,
    output logic                     overrun,
    output logic                     parity_err
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
`ifdef PARITY_CHECK_EN
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
`endif

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    collect_state_e   state_q, state_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pend_word_q, pend_word_d;
    logic             pend_perr_q, pend_perr_d;
    logic             dir_eff_s;
    logic [WIDTH-1:0] shifted_s;

    // Accumulate bits, track position and direction, stage completed frames.
    always_comb begin
        dir_eff_s   = (cnt_q == CNT_ZERO) ? msb_first : dir_q;
        shifted_s   = dir_eff_s ? {acc_q[WIDTH-2:0], bit_in}
                                : {bit_in, acc_q[WIDTH-1:1]};
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        state_d     = state_q;
        pend_d      = 1'b0;
        pend_word_d = pend_word_q;
        pend_perr_d = pend_perr_q;

        if (flush) begin
            // Flush beats any bit in the same cycle, including a completing one.
            acc_d   = {WIDTH{1'b0}};
            cnt_d   = CNT_ZERO;
            state_d = COLLECT;
        end else if (bit_valid) begin
            case (state_q)
                COLLECT: begin
                    dir_d = dir_eff_s;
                    if (cnt_q == CNT_LAST) begin
`ifdef PARITY_CHECK_EN
                        acc_d   = shifted_s;
                        cnt_d   = CNT_FULL;
                        state_d = PARITY;
`else
                        acc_d       = {WIDTH{1'b0}};
                        cnt_d       = CNT_ZERO;
                        pend_d      = 1'b1;
                        pend_word_d = shifted_s;
                        pend_perr_d = 1'b0;
`endif
                    end else begin
                        acc_d = shifted_s;
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
`ifdef PARITY_CHECK_EN
                PARITY: begin
                    // Incoming bit is the even-parity bit for the held data.
                    acc_d       = {WIDTH{1'b0}};
                    cnt_d       = CNT_ZERO;
                    state_d     = COLLECT;
                    pend_d      = 1'b1;
                    pend_word_d = acc_q;
                    pend_perr_d = bit_in ^ even_parity(32'(acc_q));
                end
`endif
                default: begin
                    acc_d   = {WIDTH{1'b0}};
                    cnt_d   = CNT_ZERO;
                    state_d = COLLECT;
                end
            endcase
        end else begin
            acc_d = acc_q;
        end
    end

    // Collector state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= {WIDTH{1'b0}};
            cnt_q       <= CNT_ZERO;
            dir_q       <= 1'b0;
            state_q     <= COLLECT;
            pend_q      <= 1'b0;
            pend_word_q <= {WIDTH{1'b0}};
            pend_perr_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_word_q <= pend_word_d;
            pend_perr_q <= pend_perr_d;
        end
    end

    assign bit_count = cnt_q;

    word_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .load_req   (pend_q),
        .load_word  (pend_word_q),
        .load_perr  (pend_perr_q),
        .word_ready (word_ready),
        .ovr_clr    (ovr_clr),
        .word_out   (word_out),
        .word_valid (word_valid),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

endmodule
